// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : traffic_pkg                                            |
// | Description : Shared state encoding and default timing constants for |
// |               the intersection light controller and the pedestrian   |
// |               crossing scheduler.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package traffic_pkg;

    // Pedestrian scheduler phases; IDLE must stay at zero (reset value).
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WALK_NS  = 3'd1,
        ST_CLEAR_NS = 3'd2,
        ST_WALK_EW  = 3'd3,
        ST_CLEAR_EW = 3'd4
    } ped_state_t;

    // System clock rate the default timings are derived from.
    localparam int unsigned c_CLK_HZ          = 50_000_000;
    // 10 ms button stability window.
    localparam int unsigned c_DEBOUNCE_CYCLES = c_CLK_HZ / 100;
    // 7 s WALK, 5 s flashing DON'T WALK.
    localparam int unsigned c_WALK_TIME       = c_CLK_HZ * 7;
    localparam int unsigned c_CLEAR_TIME      = c_CLK_HZ * 5;
    // 0.5 s flash half-period, shared with the light controller.
    localparam int unsigned c_FLASH_TIME      = c_CLK_HZ / 2;

endpackage
`default_nettype wire

// File: rtl/ped_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ped_debounce                                           |
// | Description : 2-FF synchronizer, stability counter and registered    |
// |               rising-edge pulse for one raw crosswalk button.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ped_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic rise_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned    c_CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [1:0]      sync_q;
    logic [c_CW-1:0] cnt_q;
    logic            level_q;
    logic            rise_q;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], button_i};
        end
    end

    // Accept a new level only after it has been seen for the full window;
    // any return to the accepted level restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == c_CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + c_CNT_ONE;
            end
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/ped_crossing_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ped_crossing_scheduler                                 |
// | Description : Latches debounced crosswalk presses, requests service  |
// |               from the light controller and sequences the WALK /     |
// |               flashing DON'T WALK heads on the granted green.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ped_crossing_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int unsigned WALK_TIME       = c_WALK_TIME,
    parameter int unsigned CLEAR_TIME      = c_CLEAR_TIME,
    parameter int unsigned FLASH_TIME      = c_FLASH_TIME
) (
    input  logic clk,
    input  logic reset,
    input  logic ns_button,
    input  logic ew_button,
    input  logic ns_green,
    input  logic ew_green,
    input  logic hold,
    output logic ns_ped_req,
    output logic ew_ped_req,
    output logic ns_walk,
    output logic ns_dont_walk,
    output logic ew_walk,
    output logic ew_dont_walk,
    output logic busy
);

    localparam logic [31:0] c_WALK_LAST  = 32'(WALK_TIME - 1);
    localparam logic [31:0] c_CLEAR_LAST = 32'(CLEAR_TIME - 1);
    localparam logic [31:0] c_FLASH_LAST = 32'(FLASH_TIME - 1);

    ped_state_t  state_q;
    logic [31:0] phase_cnt_q;
    logic [31:0] flash_cnt_q;
    logic        ns_pending_q, ns_pending_d;
    logic        ew_pending_q, ew_pending_d;
    logic        ns_green_prev_q, ew_green_prev_q;
    logic        ns_req_q, ew_req_q;
    logic        ns_walk_q, ns_dw_q, ew_walk_q, ew_dw_q;

    logic        w_ns_rise, w_ew_rise;
    logic        w_both_green;
    logic        w_ns_start, w_ew_start;
    logic        w_ns_active, w_ew_active;

    ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ns_debounce (
        .clk      (clk),
        .reset    (reset),
        .button_i (ns_button),
        .rise_o   (w_ns_rise)
    );

    ped_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew_debounce (
        .clk      (clk),
        .reset    (reset),
        .button_i (ew_button),
        .rise_o   (w_ew_rise)
    );

    // Both greens at once is an illegal controller state: never start a walk.
    assign w_both_green = ns_green & ew_green;
    assign w_ns_start   = (state_q == ST_IDLE) & ~hold & ~w_both_green &
                          ns_green & ~ns_green_prev_q & ns_pending_q;
    assign w_ew_start   = (state_q == ST_IDLE) & ~hold & ~w_both_green & ~w_ns_start &
                          ew_green & ~ew_green_prev_q & ew_pending_q;
    assign w_ns_active  = (state_q == ST_WALK_NS) | (state_q == ST_CLEAR_NS);
    assign w_ew_active  = (state_q == ST_WALK_EW) | (state_q == ST_CLEAR_EW);

    // Pending flags: cleared when their walk starts, set by a press unless
    // that direction is currently being served.
    always_comb begin
        ns_pending_d = ns_pending_q;
        ew_pending_d = ew_pending_q;
        if (w_ns_start) ns_pending_d = 1'b0;
        if (w_ew_start) ew_pending_d = 1'b0;
        if (w_ns_rise && !w_ns_active) ns_pending_d = 1'b1;
        if (w_ew_rise && !w_ew_active) ew_pending_d = 1'b1;
    end

    // Register pending flags, request levels and previous greens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ns_pending_q    <= 1'b0;
            ew_pending_q    <= 1'b0;
            ns_req_q        <= 1'b0;
            ew_req_q        <= 1'b0;
            ns_green_prev_q <= 1'b0;
            ew_green_prev_q <= 1'b0;
        end else begin
            ns_pending_q    <= ns_pending_d;
            ew_pending_q    <= ew_pending_d;
            ns_req_q        <= ns_pending_q & ew_green & ~hold & ~w_both_green;
            ew_req_q        <= ew_pending_q & ns_green & ~hold & ~w_both_green;
            ns_green_prev_q <= ns_green;
            ew_green_prev_q <= ew_green;
        end
    end

    // Phase FSM with registered signal heads; hold forces a clean IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            flash_cnt_q <= '0;
            ns_walk_q   <= 1'b0;
            ns_dw_q     <= 1'b1;
            ew_walk_q   <= 1'b0;
            ew_dw_q     <= 1'b1;
        end else if (hold) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            flash_cnt_q <= '0;
            ns_walk_q   <= 1'b0;
            ns_dw_q     <= 1'b1;
            ew_walk_q   <= 1'b0;
            ew_dw_q     <= 1'b1;
        end else begin
            phase_cnt_q <= phase_cnt_q + 32'd1;
            flash_cnt_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    phase_cnt_q <= '0;
                    if (w_ns_start) begin
                        state_q   <= ST_WALK_NS;
                        ns_walk_q <= 1'b1;
                        ns_dw_q   <= 1'b0;
                    end else if (w_ew_start) begin
                        state_q   <= ST_WALK_EW;
                        ew_walk_q <= 1'b1;
                        ew_dw_q   <= 1'b0;
                    end
                end
                ST_WALK_NS: begin
                    if (!ns_green || phase_cnt_q == c_WALK_LAST) begin
                        state_q     <= ST_CLEAR_NS;
                        phase_cnt_q <= '0;
                        ns_walk_q   <= 1'b0;
                        ns_dw_q     <= 1'b1;
                    end
                end
                ST_CLEAR_NS: begin
                    if (phase_cnt_q == c_CLEAR_LAST) begin
                        state_q     <= ST_IDLE;
                        phase_cnt_q <= '0;
                        ns_dw_q     <= 1'b1;
                    end else if (flash_cnt_q == c_FLASH_LAST) begin
                        ns_dw_q <= ~ns_dw_q;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 32'd1;
                    end
                end
                ST_WALK_EW: begin
                    if (!ew_green || phase_cnt_q == c_WALK_LAST) begin
                        state_q     <= ST_CLEAR_EW;
                        phase_cnt_q <= '0;
                        ew_walk_q   <= 1'b0;
                        ew_dw_q     <= 1'b1;
                    end
                end
                ST_CLEAR_EW: begin
                    if (phase_cnt_q == c_CLEAR_LAST) begin
                        state_q     <= ST_IDLE;
                        phase_cnt_q <= '0;
                        ew_dw_q     <= 1'b1;
                    end else if (flash_cnt_q == c_FLASH_LAST) begin
                        ew_dw_q <= ~ew_dw_q;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    phase_cnt_q <= '0;
                    ns_walk_q   <= 1'b0;
                    ns_dw_q     <= 1'b1;
                    ew_walk_q   <= 1'b0;
                    ew_dw_q     <= 1'b1;
                end
            endcase
        end
    end

    assign ns_ped_req   = ns_req_q;
    assign ew_ped_req   = ew_req_q;
    assign ns_walk      = ns_walk_q;
    assign ns_dont_walk = ns_dw_q;
    assign ew_walk      = ew_walk_q;
    assign ew_dont_walk = ew_dw_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ped_crossing_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ped_crossing_scheduler                              |
// | Description : Directed and random stimulus for the pedestrian        |
// |               scheduler, checked every cycle against a time-stamp    |
// |               based reference model.                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ped_crossing_scheduler;

    localparam int DB = 4;
    localparam int WT = 20;
    localparam int CT = 10;
    localparam int FT = 2;

    logic clk = 1'b0;
    logic reset, ns_button, ew_button, ns_green, ew_green, hold;
    logic ns_ped_req, ew_ped_req, ns_walk, ns_dont_walk, ew_walk, ew_dont_walk, busy;

    always #5 clk = ~clk;

    ped_crossing_scheduler #(
        .DEBOUNCE_CYCLES(DB), .WALK_TIME(WT), .CLEAR_TIME(CT), .FLASH_TIME(FT)
    ) dut (
        .clk(clk), .reset(reset), .ns_button(ns_button), .ew_button(ew_button),
        .ns_green(ns_green), .ew_green(ew_green), .hold(hold),
        .ns_ped_req(ns_ped_req), .ew_ped_req(ew_ped_req),
        .ns_walk(ns_walk), .ns_dont_walk(ns_dont_walk),
        .ew_walk(ew_walk), .ew_dont_walk(ew_dont_walk), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase kind, direction, and the edge number the phase began.
    int        n_m;
    int        ph_m;          // 0 idle, 1 walk, 2 clear
    int        dir_m;         // 0 ns, 1 ew
    int        start_m;
    bit        pend_m[2], pulse_m[2], stable_m[2], pg_m[2], req_m[2];
    bit [15:0] hist_m[2];     // bit k = raw button sampled k edges ago

    task automatic model_reset();
        ph_m = 0; dir_m = 0; start_m = 0;
        for (int d = 0; d < 2; d++) begin
            pend_m[d] = 1'b0; pulse_m[d] = 1'b0; stable_m[d] = 1'b0;
            pg_m[d] = 1'b0; req_m[d] = 1'b0; hist_m[d] = '0;
        end
    endtask

    task automatic model_step();
        bit g[2], btn[2], act[2], both, v, same;
        int started;
        n_m++;
        g[0] = ns_green; g[1] = ew_green; btn[0] = ns_button; btn[1] = ew_button;
        both = g[0] & g[1];
        for (int d = 0; d < 2; d++) act[d] = (ph_m != 0) && (dir_m == d);
        req_m[0] = pend_m[0] & g[1] & !hold & !both;
        req_m[1] = pend_m[1] & g[0] & !hold & !both;
        started = -1;
        if (hold) ph_m = 0;
        else if (ph_m == 0) begin
            if (!both)
                for (int d = 0; d < 2; d++)
                    if (started < 0 && g[d] && !pg_m[d] && pend_m[d]) begin
                        ph_m = 1; dir_m = d; start_m = n_m; started = d;
                    end
        end else if (ph_m == 1) begin
            if (!g[dir_m] || (n_m - start_m) == WT) begin ph_m = 2; start_m = n_m; end
        end else if ((n_m - start_m) == CT) ph_m = 0;
        if (started >= 0) pend_m[started] = 1'b0;
        for (int d = 0; d < 2; d++) if (pulse_m[d] && !act[d]) pend_m[d] = 1'b1;
        // A level is accepted once the synchronized button held it DB samples.
        for (int d = 0; d < 2; d++) begin
            hist_m[d]  = {hist_m[d][14:0], btn[d]};
            pulse_m[d] = 1'b0;
            v = hist_m[d][2]; same = 1'b1;
            for (int k = 3; k <= DB + 1; k++) if (hist_m[d][k] != v) same = 1'b0;
            if (same && v != stable_m[d]) begin stable_m[d] = v; pulse_m[d] = v; end
        end
        pg_m[0] = g[0]; pg_m[1] = g[1];
    endtask

    function automatic bit exp_walk(input int d);
        return (ph_m == 1) && (dir_m == d);
    endfunction

    function automatic bit exp_dw(input int d);
        if (ph_m == 1 && dir_m == d) return 1'b0;
        if (ph_m == 2 && dir_m == d) return (((n_m - start_m) / FT) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic check_all();
        check_val("ns_ped_req",   ns_ped_req,   req_m[0]);
        check_val("ew_ped_req",   ew_ped_req,   req_m[1]);
        check_val("ns_walk",      ns_walk,      exp_walk(0));
        check_val("ns_dont_walk", ns_dont_walk, exp_dw(0));
        check_val("ew_walk",      ew_walk,      exp_walk(1));
        check_val("ew_dont_walk", ew_dont_walk, exp_dw(1));
        check_val("busy",         busy,         ph_m != 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    bit pat[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int r;

    initial begin
        n_m = 0;
        model_reset();
        reset = 1'b1; ns_button = 1'b0; ew_button = 1'b0;
        ns_green = 1'b0; ew_green = 1'b0; hold = 1'b0;
        run(2);
        check_val("rst_ns_walk", ns_walk, 1'b0);
        check_val("rst_ns_dw",   ns_dont_walk, 1'b1);
        check_val("rst_ew_dw",   ew_dont_walk, 1'b1);
        check_val("rst_busy",    busy, 1'b0);
        reset = 1'b0;

        // Glitch shorter than the debounce window.
        ew_green = 1'b1;
        ns_button = 1'b1; run(3); ns_button = 1'b0; run(12);
        check_val("glitch_req", ns_ped_req, 1'b0);

        // Clean press: request exactly 8 cycles after the raw edge.
        ns_button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 7) check_val("req_lat7", ns_ped_req, 1'b0);
            if (i == 8) check_val("req_lat8", ns_ped_req, 1'b1);
        end
        ns_button = 1'b0; run(10);

        // NS service: 20 walk cycles, 10 flashing clear cycles, then idle.
        ew_green = 1'b0; ns_green = 1'b1;
        for (int i = 0; i < WT; i++) begin step(); check_val("walk_on", ns_walk, 1'b1); end
        for (int i = 0; i < CT; i++) begin
            step();
            check_val("clear_walk", ns_walk, 1'b0);
            check_val("flash_pat", ns_dont_walk, pat[i]);
        end
        step();
        check_val("svc_idle", busy, 1'b0);

        // Early green drop at walk cycle 8; clear still runs its full length.
        ns_button = 1'b1; run(10); ns_button = 1'b0; run(8);
        ns_green = 1'b0; ew_green = 1'b1; run(3);
        ew_green = 1'b0; ns_green = 1'b1; run(8);
        check_val("drop_walk", ns_walk, 1'b1);
        ns_green = 1'b0;
        step();
        check_val("drop_clear", ns_walk, 1'b0);
        for (int i = 2; i <= CT; i++) begin step(); check_val("drop_busy", busy, 1'b1); end
        step();
        check_val("drop_idle", busy, 1'b0);

        // Hold during CLEAR_EW aborts; an NS press made during the EW walk survives.
        ns_green = 1'b1;
        ew_button = 1'b1; run(10); ew_button = 1'b0; run(4);
        check_val("ew_req", ew_ped_req, 1'b1);
        ns_green = 1'b0; ew_green = 1'b1; step();
        check_val("ew_walk", ew_walk, 1'b1);
        ns_button = 1'b1; run(8); ns_button = 1'b0; run(2);
        run(9); step(); run(3);
        check_val("ew_in_clear", busy, 1'b1);
        hold = 1'b1; step();
        check_val("hold_idle", busy, 1'b0);
        check_val("hold_ew_req", ew_ped_req, 1'b0);
        check_val("hold_ew_dw", ew_dont_walk, 1'b1);
        hold = 1'b0; step();
        check_val("hold_keep_pend", ns_ped_req, 1'b1);
        ew_green = 1'b0; ns_green = 1'b1; run(31);
        check_val("ns2_idle", busy, 1'b0);

        // Both buttons at once: NS requested first, EW once NS is green.
        ns_green = 1'b0; ew_green = 1'b1; run(2);
        ns_button = 1'b1; ew_button = 1'b1; run(10);
        ns_button = 1'b0; ew_button = 1'b0; run(2);
        check_val("both_ns_req", ns_ped_req, 1'b1);
        check_val("both_ew_req0", ew_ped_req, 1'b0);
        ew_green = 1'b0; ns_green = 1'b1; run(5);
        check_val("both_ns_walk", ns_walk, 1'b1);
        check_val("both_ew_req1", ew_ped_req, 1'b1);

        // Asynchronous reset mid-walk.
        #2 reset = 1'b1;
        #1;
        check_val("arst_ns_walk", ns_walk, 1'b0);
        check_val("arst_ns_dw",   ns_dont_walk, 1'b1);
        check_val("arst_ew_dw",   ew_dont_walk, 1'b1);
        check_val("arst_ew_req",  ew_ped_req, 1'b0);
        check_val("arst_busy",    busy, 1'b0);
        step();
        reset = 1'b0;
        run(5);
        check_val("arst_pend_clr", ew_ped_req, 1'b0);
        check_val("arst_idle", busy, 1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) ns_button = ~ns_button;
            if ($urandom_range(0, 5) == 0) ew_button = ~ew_button;
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 9);
                ns_green = (r < 4) || (r == 9);
                ew_green = (r >= 4 && r < 8) || (r == 9);
            end
            if (hold) hold = ($urandom_range(0, 3) != 0);
            else      hold = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
